// File: rtl/mmio_bram_ctrl_if.sv
// ---------------------------------------------------------------------------
// mmio_bram_ctrl_if
//   Bus bundle for mmio_bram_ctrl: CPU data port A and display read port B.
//
//   Port A (CPU):
//     en_a    access strobe
//     we_a    write enable, qualified by en_a
//     addr_a  CPU address
//     data_a  CPU write data
//     q_a     CPU read data, one cycle after an accepted read
//     stall_a access in this cycle was not performed; CPU must repeat it
//   Port B (display, read-only):
//     addr_b  read address
//     q_b     read data, one cycle latency
//
//   Modports:
//     master  CPU / display side (drives requests, receives data)
//     slave   memory controller side
// ---------------------------------------------------------------------------
interface mmio_bram_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  en_a;
    logic                  we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] q_a;
    logic                  stall_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] q_b;

    modport master (
        output en_a, we_a, addr_a, data_a, addr_b,
        input  q_a, stall_a, q_b
    );

    modport slave (
        input  en_a, we_a, addr_a, data_a, addr_b,
        output q_a, stall_a, q_b
    );
endinterface

// File: rtl/mmio_bram_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_bram_ctrl
//   Dual-port block RAM with a bank of NUM_CONT read-only controller
//   registers mapped at MMIO_BASE .. MMIO_BASE+NUM_CONT-1.
//
//   Controller inputs are double-flopped, compared against the value last
//   copied into RAM, and changed channels are written into RAM on idle
//   port-A cycles (round-robin), so the display port always sees current
//   controller state. If the CPU keeps port A busy for STARVE_LIMIT cycles
//   while an update is pending, one CPU cycle is stalled and the update is
//   forced in.
//
//   Ports:
//     clk      rising-edge clock
//     reset    asynchronous, active-high reset
//     cont     controller inputs, channel i at [i*DATA_WIDTH +: DATA_WIDTH],
//              asynchronous to clk
//     pending  per-channel "RAM copy is stale" flags
//     bus      mmio_bram_ctrl_if.slave (port A CPU, port B display)
//
//   Optional build macro:
//     MMIO_EDGE_LATCH_EN  CPU reads of a controller register return an
//                         OR-accumulated (sticky) value that is cleared to
//                         the current input on read. Without it, CPU reads
//                         return the live synchronised input.
// ---------------------------------------------------------------------------
module mmio_bram_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_CONT     = 2,
    parameter int MMIO_BASE    = 'hC001,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] cont,
    output logic [NUM_CONT-1:0]            pending,
    mmio_bram_ctrl_if.slave                bus
);

    localparam int PTR_W = (NUM_CONT > 1) ? $clog2(NUM_CONT) : 1;
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(MMIO_BASE);
    localparam logic [ADDR_WIDTH-1:0] NCONT_A   = ADDR_WIDTH'(NUM_CONT);
    localparam logic [PTR_W-1:0]      LAST_CH   = PTR_W'(NUM_CONT - 1);
    localparam logic [CNT_W-1:0]      LIMIT_CNT = CNT_W'(STARVE_LIMIT);
    localparam bit                    FORCE_EN  = (STARVE_LIMIT != 0);

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic [DATA_WIDTH-1:0] cont_p0 [NUM_CONT];
    logic [DATA_WIDTH-1:0] cont_p1 [NUM_CONT];
    logic [DATA_WIDTH-1:0] written [NUM_CONT];

    logic [PTR_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]      starve_cnt;

    logic                  pend_any;
    logic [PTR_W-1:0]      sel;
    logic                  sel_found;
    logic                  force_inj;
    logic                  inject;
    logic                  cpu_acc;
    logic [ADDR_WIDTH-1:0] inj_addr;
    logic [DATA_WIDTH-1:0] inj_data;

    logic [ADDR_WIDTH-1:0] addr_off;
    logic                  in_window;
    logic [PTR_W-1:0]      chan;
    logic [DATA_WIDTH-1:0] mmio_rd;

    // ---- stage p0/p1: two-flop synchroniser per channel (no multi-bit coherence)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CONT; i++) begin
                cont_p0[i] <= '0;
                cont_p1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CONT; i++) begin
                cont_p0[i] <= cont[i*DATA_WIDTH +: DATA_WIDTH];
                cont_p1[i] <= cont_p0[i];
            end
        end
    end

    // ---- change tracking and arbitration (combinational on the p1 values)
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_CONT; i++) begin
            pending[i] = (cont_p1[i] != written[i]);
        end
    end

    assign pend_any = |pending;

    // Round-robin: first pending channel at or above the pointer, otherwise
    // the lowest pending channel (wrap-around).
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_CONT; i++) begin
            if (!sel_found && pending[i] && (PTR_W'(i) >= rr_ptr)) begin
                sel       = PTR_W'(i);
                sel_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CONT; i++) begin
            if (!sel_found && pending[i]) begin
                sel       = PTR_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        inj_data = '0;
        for (int i = 0; i < NUM_CONT; i++) begin
            if (sel == PTR_W'(i)) begin
                inj_data = cont_p1[i];
            end
        end
    end

    assign inj_addr = BASE_A + ADDR_WIDTH'(sel);

    // A saturated counter with work still pending steals this port-A cycle.
    assign force_inj   = FORCE_EN && (starve_cnt == LIMIT_CNT) && pend_any;
    assign bus.stall_a = force_inj;
    assign inject      = pend_any && (!bus.en_a || force_inj);
    assign cpu_acc     = bus.en_a && !force_inj;

    // ---- MMIO window decode
    // Wrap-around subtraction is safe: the window never crosses the top of
    // the address space, and the >= test rejects addresses below the base.
    assign addr_off  = bus.addr_a - BASE_A;
    assign in_window = (bus.addr_a >= BASE_A) && (addr_off < NCONT_A);
    assign chan      = PTR_W'(addr_off);

`ifdef MMIO_EDGE_LATCH_EN
    logic [DATA_WIDTH-1:0] sticky [NUM_CONT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CONT; i++) begin
                sticky[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CONT; i++) begin
                // Read-to-clear reloads the live value so a level still held
                // high stays visible on the next read.
                if (cpu_acc && !bus.we_a && in_window && (chan == PTR_W'(i))) begin
                    sticky[i] <= cont_p1[i];
                end else begin
                    sticky[i] <= sticky[i] | cont_p1[i];
                end
            end
        end
    end

    always_comb begin
        mmio_rd = '0;
        for (int i = 0; i < NUM_CONT; i++) begin
            if (chan == PTR_W'(i)) begin
                mmio_rd = sticky[i];
            end
        end
    end
`else
    always_comb begin
        mmio_rd = '0;
        for (int i = 0; i < NUM_CONT; i++) begin
            if (chan == PTR_W'(i)) begin
                mmio_rd = cont_p1[i];
            end
        end
    end
`endif

    // ---- injection bookkeeping: written copy, pointer, starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CONT; i++) begin
                written[i] <= '0;
            end
            rr_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (inject) begin
                for (int i = 0; i < NUM_CONT; i++) begin
                    if (sel == PTR_W'(i)) begin
                        written[i] <= cont_p1[i];
                    end
                end
                rr_ptr <= (sel == LAST_CH) ? '0 : sel + PTR_W'(1);
            end

            if (inject || !pend_any) begin
                starve_cnt <= '0;
            end else if (bus.en_a && (starve_cnt != LIMIT_CNT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // ---- RAM write port (port A: injection or CPU write outside the window)
    // Injection and a performed CPU access are mutually exclusive by
    // construction, so a single write port suffices.
    always_ff @(posedge clk) begin
        if (inject) begin
            ram[inj_addr] <= inj_data;
        end else if (cpu_acc && bus.we_a && !in_window) begin
            ram[bus.addr_a] <= bus.data_a;
        end
    end

    // ---- read data registers (RAM is read before the same-edge write lands)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.q_a <= '0;
            bus.q_b <= '0;
        end else begin
            bus.q_b <= ram[bus.addr_b];
            if (cpu_acc && !bus.we_a) begin
                bus.q_a <= in_window ? mmio_rd : ram[bus.addr_a];
            end
        end
    end

endmodule

// File: tb/tb_mmio_bram_ctrl.sv
module tb_mmio_bram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cont;
    logic [1:0]  pending;

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] sb_q [$];
    logic [15:0] mq;
    logic [15:0] e_clr, e_hi, e_lo;

    mmio_bram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    mmio_bram_ctrl #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (16),
        .NUM_CONT    (2),
        .MMIO_BASE   ('hC001),
        .STARVE_LIMIT(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cont   (cont),
        .pending(pending),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] ab;
        logic [15:0] exp_q;
        logic        chk_qb;
        logic [15:0] exp_qb;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic cyc(input logic en, input logic we, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] ab,
                       input logic [15:0] exp_q, input logic exp_stall,
                       input logic chk_pend, input logic [1:0] exp_pend,
                       input logic chk_qb, input logic [15:0] exp_qb);
        logic [15:0] e;
        bus.en_a   = en;
        bus.we_a   = we;
        bus.addr_a = addr;
        bus.data_a = wd;
        bus.addr_b = ab;
        sb_q.push_back(exp_q);
        #1;
        check("stall_a", 16'(bus.stall_a), 16'(exp_stall));
        if (chk_pend) check("pending", 16'(pending), 16'(exp_pend));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("q_a", bus.q_a, e);
        if (chk_qb) check("q_b", bus.q_b, exp_qb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        cont        = {16'h0000, 16'h0005};
        bus.en_a    = 1'b0;
        bus.we_a    = 1'b0;
        bus.addr_a  = '0;
        bus.data_a  = '0;
        bus.addr_b  = 16'hC001;
        mq          = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_q_a", bus.q_a, 16'h0000);
        check("rst_q_b", bus.q_b, 16'h0000);
        check("rst_stall", 16'(bus.stall_a), 16'h0000);
        check("rst_pending", 16'(pending), 16'h0000);
        reset = 1'b0;

        // Power-up injection of a nonzero channel
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b01, 0, 0);
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b00, 1, 16'h0005);
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b00, 1, 16'h0005);

        // Async reset, then two channels change together: round-robin order
        reset = 1'b1;
        cont  = {16'h0022, 16'h0011};
        #1;
        check("async_rst_pending", 16'(pending), 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b11, 0, 0);
        cyc(0, 0, 0, 0, 16'hC001, mq, 0, 1, 2'b10, 1, 16'h0011);
        cyc(0, 0, 0, 0, 16'hC002, mq, 0, 1, 2'b00, 1, 16'h0022);
        cyc(0, 0, 0, 0, 16'hC002, mq, 0, 1, 2'b00, 0, 0);

        // CPU access vectors: window discard/live read, RAM r/w, port-B RBW
        tbl[0]  = '{1'b1, 1'b1, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 16'hC001, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 16'hC001, 16'h0000, 16'hC001, 16'h0011, 1'b1, 16'h0011};
        tbl[3]  = '{1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 16'h0011, 1'b0, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0100, 16'hBEEF, 1'b1, 16'hBEEF};
        tbl[5]  = '{1'b1, 1'b0, 16'hC002, 16'h0000, 16'hC002, 16'h0022, 1'b1, 16'h0022};
        tbl[6]  = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'h0200, 16'h0022, 1'b1, 16'h0000};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0200, 16'h0022, 1'b1, 16'h1234};
        tbl[8]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 16'h1234, 1'b0, 16'h0000};
        tbl[9]  = '{1'b1, 1'b1, 16'hC002, 16'h5555, 16'hC002, 16'h1234, 1'b1, 16'h0022};
        tbl[10] = '{1'b1, 1'b1, 16'hC003, 16'h0A0A, 16'h0000, 16'h1234, 1'b0, 16'h0000};
        tbl[11] = '{1'b1, 1'b1, 16'hC000, 16'h0B0B, 16'h0000, 16'h1234, 1'b0, 16'h0000};
        tbl[12] = '{1'b1, 1'b0, 16'hC003, 16'h0000, 16'hC003, 16'h0A0A, 1'b1, 16'h0A0A};
        tbl[13] = '{1'b1, 1'b0, 16'hC000, 16'h0000, 16'hC000, 16'h0B0B, 1'b1, 16'h0B0B};
        tbl[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC002, 16'h0B0B, 1'b1, 16'h0022};
        tbl[15] = '{1'b1, 1'b0, 16'hC002, 16'h0000, 16'h0000, 16'h0022, 1'b0, 16'h0000};

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].ab,
                tbl[i].exp_q, 1'b0, 1'b1, 2'b00, tbl[i].chk_qb, tbl[i].exp_qb);
        end
        mq = 16'h0022;

        // Starvation: back-to-back RAM reads while ch1 changes
        cont = {16'h0033, 16'h0011};
        for (int j = 0; j <= 12; j++) begin
            logic [15:0] a;
            logic [1:0]  ep;
            a  = (j % 2 == 0) ? 16'h0100 : 16'h0200;
            ep = (j >= 2 && j <= 10) ? 2'b10 : 2'b00;
            if (j != 10) mq = (j % 2 == 0) ? 16'hBEEF : 16'h1234;
            cyc(1, 0, a, 0, 16'hC002, mq, (j == 10), 1, ep,
                1, (j >= 11) ? 16'h0033 : 16'h0022);
        end

        // Controller register read semantics (sticky or live)
`ifdef MMIO_EDGE_LATCH_EN
        e_clr = 16'h0011;
        e_hi  = 16'h0001;
        e_lo  = 16'h0000;
`else
        e_clr = 16'h0000;
        e_hi  = 16'h0000;
        e_lo  = 16'h0000;
`endif
        cont[15:0] = 16'h0000;
        repeat (4) cyc(0, 0, 0, 0, 0, mq, 0, 0, 2'b00, 0, 0);
        mq = e_clr;
        cyc(1, 0, 16'hC001, 0, 0, mq, 0, 0, 2'b00, 0, 0);
        cont[15:0] = 16'h0001;
        cyc(0, 0, 0, 0, 0, mq, 0, 0, 2'b00, 0, 0);
        cont[15:0] = 16'h0000;
        repeat (3) cyc(0, 0, 0, 0, 0, mq, 0, 0, 2'b00, 0, 0);
        mq = e_hi;
        cyc(1, 0, 16'hC001, 0, 0, mq, 0, 0, 2'b00, 0, 0);
        mq = e_lo;
        cyc(1, 0, 16'hC001, 0, 0, mq, 0, 0, 2'b00, 0, 0);

        // Reset mid-operation: q_a drops to 0 immediately
        mq = 16'hBEEF;
        cyc(1, 0, 16'h0100, 0, 16'h0100, mq, 0, 0, 2'b00, 1, 16'hBEEF);
        reset = 1'b1;
        #1;
        check("midrst_q_a", bus.q_a, 16'h0000);
        check("midrst_q_b", bus.q_b, 16'h0000);
        check("midrst_pending", 16'(pending), 16'h0000);
        bus.en_a = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq = 16'h0000;
        cyc(0, 0, 0, 0, 0, mq, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, mq, 0, 1, 2'b00, 0, 0);
        cyc(0, 0, 0, 0, 0, mq, 0, 1, 2'b10, 0, 0);
        cyc(0, 0, 0, 0, 16'hC002, mq, 0, 1, 2'b00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
